tff_counter_bank: RTL and testbench



---
 rtl/tff_counter_bank.sv | 107 ++++++++++
 tb/tb_tff_counter_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tff_counter_bank.sv
// tff_counter_bank: a bank of WIDTH T flip-flops that can hold, toggle per bit,
// or count up/down modulo MOD. It also has a parallel load, a registered
// terminal-count pulse and a sticky wrap flag.
//
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous active-high reset
//   enable   1 = apply mode this cycle, 0 = hold (load still applies)
//   mode     00 hold, 01 toggle, 10 count up, 11 count down
//   t        per-bit toggle request (mode 01 only)
//   load     synchronous parallel load of data_in, highest priority
//   data_in  load value
//   q        registered bank state
//   not_q    ~q, forced to all-0 while reset is high
//   tc       one-cycle pulse while q shows a wrapped count value
//   wrapped  sticky flag, set by a count wrap, cleared by reset or load
module tff_counter_bank #(
    parameter int WIDTH       = 4,
    parameter int MOD         = 16,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] not_q,
    output logic             tc,
    output logic             wrapped
);

    // Compare and step one bit wider than q.
    // This keeps MOD == 2**WIDTH representable.
    localparam logic [WIDTH:0]   LAST  = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH:0]   MODX  = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0]   ONE   = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

    logic [WIDTH:0]   q_x;
    logic [WIDTH:0]   q_inc;
    logic [WIDTH:0]   q_dec;
    logic [WIDTH-1:0] q_n;
    logic             tc_n;
    logic             wrapped_n;

    assign q_x   = {1'b0, q};
    assign q_inc = q_x + ONE;
    assign q_dec = q_x - ONE;

    always_comb begin
        q_n       = q;
        tc_n      = 1'b0;
        wrapped_n = wrapped;
        if (load) begin
            q_n       = data_in;
            wrapped_n = 1'b0;
        end else if (enable) begin
            unique case (mode)
                2'b00: q_n = q;
                2'b01: q_n = q ^ t;
                2'b10: begin
                    if (q_x == LAST) begin
                        q_n       = '0;
                        tc_n      = 1'b1;
                        wrapped_n = 1'b1;
                    end else if (q_x >= MODX) begin
                        // out-of-range value left by a load
                        q_n = '0;
                    end else begin
                        q_n = q_inc[WIDTH-1:0];
                    end
                end
                2'b11: begin
                    if (q_x == '0) begin
                        q_n       = LAST[WIDTH-1:0];
                        tc_n      = 1'b1;
                        wrapped_n = 1'b1;
                    end else if (q_x >= MODX) begin
                        q_n = LAST[WIDTH-1:0];
                    end else begin
                        q_n = q_dec[WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q       <= RST_Q;
            tc      <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            q       <= q_n;
            tc      <= tc_n;
            wrapped <= wrapped_n;
        end
    end

    // Gated by reset so the decoders downstream see a blank value
    // during reset.
    assign not_q = reset ? '0 : ~q;

endmodule

// File: tb/tb_tff_counter_bank.sv
// Testbench for tff_counter_bank: MOD=10 and MOD=16 instances
// are driven in parallel and checked against an integer reference model.
module tb_tff_counter_bank;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] t = 4'h0;
    logic       load = 1'b0;
    logic [3:0] data_in = 4'h0;

    logic [3:0] q_a, nq_a, q_b, nq_b;
    logic       tc_a, wr_a, tc_b, wr_b;

    int n_assert = 0;
    int n_fail   = 0;

    int mods[2] = '{10, 16};
    int mq[2];
    int mtc[2];
    int mwr[2];

    always #5 clock = ~clock;

    tff_counter_bank #(.WIDTH(4), .MOD(10), .RESET_VALUE(0)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode),
        .t(t), .load(load), .data_in(data_in),
        .q(q_a), .not_q(nq_a), .tc(tc_a), .wrapped(wr_a)
    );

    tff_counter_bank #(.WIDTH(4), .MOD(16), .RESET_VALUE(0)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode),
        .t(t), .load(load), .data_in(data_in),
        .q(q_b), .not_q(nq_b), .tc(tc_b), .wrapped(wr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mtc[i] = 0; mwr[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int m;
            m = mods[i];
            mtc[i] = 0;
            if (load) begin
                mq[i] = int'(data_in);
                mwr[i] = 0;
            end else if (!enable || mode == 2'd0) begin
                // hold
            end else if (mode == 2'd1) begin
                mq[i] = mq[i] ^ int'(t);
            end else if (mode == 2'd2) begin
                if (mq[i] == m - 1) begin
                    mq[i] = 0; mtc[i] = 1; mwr[i] = 1;
                end else if (mq[i] >= m) mq[i] = 0;
                else mq[i] = mq[i] + 1;
            end else begin
                if (mq[i] == 0) begin
                    mq[i] = m - 1; mtc[i] = 1; mwr[i] = 1;
                end else if (mq[i] >= m) mq[i] = m - 1;
                else mq[i] = mq[i] - 1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        int nexp[2];
        for (int i = 0; i < 2; i++)
            nexp[i] = reset ? 0 : (~mq[i]) & 15;
        chk({ph, ".a.q"},  32'(q_a),  32'(mq[0]));
        chk({ph, ".a.nq"}, 32'(nq_a), 32'(nexp[0]));
        chk({ph, ".a.tc"}, 32'(tc_a), 32'(mtc[0]));
        chk({ph, ".a.wr"}, 32'(wr_a), 32'(mwr[0]));
        chk({ph, ".b.q"},  32'(q_b),  32'(mq[1]));
        chk({ph, ".b.nq"}, 32'(nq_b), 32'(nexp[1]));
        chk({ph, ".b.tc"}, 32'(tc_b), 32'(mtc[1]));
        chk({ph, ".b.wr"}, 32'(wr_b), 32'(mwr[1]));
    endtask

    task automatic tick(input string ph);
        @(posedge clock);
        if (!reset) model_step();
        #1;
        check_all(ph);
    endtask

    initial begin
        model_reset();
        #2;
        check_all("rst_async");
        tick("rst_hold");
        tick("rst_hold");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all("rst_release");

        // 1: count up modulo 10, 12 steps
        enable = 1'b1;
        mode = 2'b10;
        for (int k = 0; k < 12; k++) tick("up");
        chk("up.final_q", 32'(q_a), 32'd2);
        chk("up.final_wr", 32'(wr_a), 32'd1);

        // 2: count down from 0
        load = 1'b1; data_in = 4'd0;
        tick("ld0");
        load = 1'b0; mode = 2'b11;
        tick("dn");
        chk("dn.wrap_q", 32'(q_a), 32'd9);
        chk("dn.wrap_tc", 32'(tc_a), 32'd1);
        tick("dn");
        tick("dn");
        chk("dn.final_q", 32'(q_a), 32'd7);

        // 3: toggle, then disabled hold
        load = 1'b1; data_in = 4'd0;
        tick("ld0");
        load = 1'b0; mode = 2'b01; t = 4'b1010;
        tick("tog");
        chk("tog.q1", 32'(q_a), 32'hA);
        tick("tog");
        chk("tog.q2", 32'(q_a), 32'h0);
        t = 4'b0110;
        tick("tog");
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mode = 2'($urandom);
            t = 4'($urandom);
            tick("hold");
        end
        enable = 1'b1;

        // 4: load beats a wrap; out-of-range load recovers
        load = 1'b1; data_in = 4'd9; mode = 2'b10;
        tick("ld9");
        load = 1'b0;
        tick("wrap");
        load = 1'b1; data_in = 4'd9;
        tick("ld9");
        data_in = 4'd3;
        tick("ld_vs_wrap");
        chk("ldwrap.q", 32'(q_a), 32'd3);
        chk("ldwrap.tc", 32'(tc_a), 32'd0);
        chk("ldwrap.wr", 32'(wr_a), 32'd0);
        data_in = 4'd14;
        tick("ld14");
        load = 1'b0;
        tick("oor_up");
        chk("oor.q", 32'(q_a), 32'd0);
        chk("oor.tc", 32'(tc_a), 32'd0);
        load = 1'b1; data_in = 4'd12;
        tick("ld12");
        load = 1'b0; mode = 2'b11;
        tick("oor_dn");

        // 5: async reset mid-count
        load = 1'b1; data_in = 4'd0; mode = 2'b10;
        tick("ld0");
        load = 1'b0;
        for (int k = 0; k < 6; k++) tick("up6");
        chk("pre_rst.q", 32'(q_a), 32'd6);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rst_mid");
        tick("rst_mid_hold");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all("rst_mid_rel");
        chk("rel.nq", 32'(nq_a), 32'hF);
        tick("restart");
        chk("restart.q", 32'(q_a), 32'd1);

        // 6: MOD=16 full-range wrap
        load = 1'b1; data_in = 4'd15;
        tick("ld15");
        load = 1'b0;
        tick("wrap16");
        chk("w16.q", 32'(q_b), 32'd0);
        chk("w16.tc", 32'(tc_b), 32'd1);

        // random soak
        for (int k = 0; k < 300; k++) begin
            enable  = ($urandom_range(0, 7) != 0);
            mode    = 2'($urandom);
            t       = 4'($urandom);
            load    = ($urandom_range(0, 9) == 0);
            data_in = 4'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                check_all("rnd_rst");
                #1;
                reset = 1'b0;
            end
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
